// File: rtl/keystroke_pkg.sv
// Shared constants, channel action encoding and the width helper used by
// the keystroke counter bank.
package keystroke_pkg;

  localparam int MODE_SATURATE = 0;
  localparam int MODE_WRAP     = 1;

  // What a channel does to its counter this cycle, after priority resolution.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_CLEAR,
    ACT_INC,
    ACT_DEC,
    ACT_WRAP
  } chan_act_e;

  // Ceiling log2 for elaboration-time widths; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/keystroke_channel.sv
// One key channel: rising-edge press detect, bounded up/down counter and
// its limit/overflow flag. Exposes the next count so the bank can keep a
// registered total that never lags the per-channel counts.
module keystroke_channel
  import keystroke_pkg::*;
#(
  parameter int CNT_W     = 4,
  parameter int MAX_CNT   = 4,
  parameter int WRAP_MODE = MODE_SATURATE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic             key_i,
  input  logic             dec_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] count_next_o,
  output logic             overflow_o
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CNT);

  logic             prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             press;
  logic             dec;
  chan_act_e        act;

  // The previous level follows the key every cycle, so a key already high
  // when enable rises is not seen as a new press.
  assign press = key_i & ~prev_q & enable_i;
  assign dec   = dec_i & enable_i;

  always_comb begin
    // NOTE: every variable written here gets a default first, otherwise
    // paths that skip an assignment would infer a latch.
    act = ACT_HOLD;
    if (clear_i) begin
      act = ACT_CLEAR;
    end else if (press && dec) begin
      act = ACT_HOLD;
    end else if (press) begin
      if (cnt_q < MAX_C)                  act = ACT_INC;
      else if (WRAP_MODE == MODE_WRAP)    act = ACT_WRAP;
      else                                act = ACT_HOLD;
    end else if (dec && (cnt_q != '0)) begin
      act = ACT_DEC;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unique case (act)
      ACT_CLEAR: begin
        cnt_d = '0;
        ovf_d = 1'b0;
      end
      ACT_INC:  cnt_d = cnt_q + CNT_W'(1);
      ACT_DEC:  cnt_d = cnt_q - CNT_W'(1);
      ACT_WRAP: begin
        cnt_d = '0;
        ovf_d = 1'b1;
      end
      default:  ;
    endcase
    // Saturating channels flag "at limit"; wrapping channels keep a sticky flag.
    if (WRAP_MODE == MODE_SATURATE) ovf_d = (cnt_d == MAX_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      prev_q <= key_i;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign count_o      = cnt_q;
  assign count_next_o = cnt_d;
  assign overflow_o   = ovf_q;

endmodule

// File: rtl/keystroke_count_bank.sv
// Bank of N_CH independent keystroke counters with a registered running
// total and a combinational "any channel full" flag.
module keystroke_count_bank
  import keystroke_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int CNT_W     = 4,
  parameter int MAX_CNT   = 4,
  parameter int WRAP_MODE = MODE_SATURATE
) (
  input  logic                        key_clk,
  input  logic                        key_reset,
  input  logic                        key_enable,
  input  logic [N_CH-1:0]             key_in,
  input  logic [N_CH-1:0]             key_dec,
  input  logic [N_CH-1:0]             key_clear,
  output logic [N_CH*CNT_W-1:0]       key_count,
  output logic [N_CH-1:0]             key_overflow,
  output logic [CNT_W+clog2(N_CH):0]  key_total,
  output logic                        key_any_full
);

  localparam int TOT_W = CNT_W + clog2(N_CH) + 1;

  logic [N_CH*CNT_W-1:0] count_next;
  logic [TOT_W-1:0]      total_q, total_d;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    keystroke_channel #(
      .CNT_W     (CNT_W),
      .MAX_CNT   (MAX_CNT),
      .WRAP_MODE (WRAP_MODE)
    ) u_ch (
      .clk          (key_clk),
      .rst_n        (key_reset),
      .enable_i     (key_enable),
      .key_i        (key_in[g]),
      .dec_i        (key_dec[g]),
      .clear_i      (key_clear[g]),
      .count_o      (key_count[g*CNT_W +: CNT_W]),
      .count_next_o (count_next[g*CNT_W +: CNT_W]),
      .overflow_o   (key_overflow[g])
    );
  end

  // Summing the channels' next counts lets the total register update on the
  // same edge as the counts themselves.
  always_comb begin
    total_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      total_d = total_d + TOT_W'(count_next[i*CNT_W +: CNT_W]);
    end
  end

  always_ff @(posedge key_clk or negedge key_reset) begin
    if (!key_reset) total_q <= '0;
    else            total_q <= total_d;
  end

  assign key_total    = total_q;
  assign key_any_full = |key_overflow;

endmodule

// File: tb/tb_keystroke_count_bank.sv
// Scoreboard bench: a saturating default bank and a wrapping MAX_CNT=3 bank
// share stimulus; a behavioural model predicts both every cycle.
module tb_keystroke_count_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] kin, kdec, kclr;

  logic [15:0] cnt_s, cnt_w;
  logic [3:0]  ovf_s, ovf_w;
  logic [6:0]  tot_s, tot_w;
  logic        any_s, any_w;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [15:0] cnt_s;
    logic [3:0]  ovf_s;
    logic [6:0]  tot_s;
    logic        any_s;
    logic [15:0] cnt_w;
    logic [3:0]  ovf_w;
    logic [6:0]  tot_w;
    logic        any_w;
  } exp_t;

  exp_t sb[$];

  // Model state: index 0 = saturating bank (max 4), 1 = wrapping bank (max 3).
  int m_cnt [2][4];
  bit m_ovf [2][4];
  bit m_prev[4];

  always #5 clk = ~clk;

  keystroke_count_bank dut_s (
    .key_clk(clk), .key_reset(rst_n), .key_enable(en),
    .key_in(kin), .key_dec(kdec), .key_clear(kclr),
    .key_count(cnt_s), .key_overflow(ovf_s), .key_total(tot_s), .key_any_full(any_s)
  );

  keystroke_count_bank #(.N_CH(4), .CNT_W(4), .MAX_CNT(3), .WRAP_MODE(1)) dut_w (
    .key_clk(clk), .key_reset(rst_n), .key_enable(en),
    .key_in(kin), .key_dec(kdec), .key_clear(kclr),
    .key_count(cnt_w), .key_overflow(ovf_w), .key_total(tot_w), .key_any_full(any_w)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 4; i++) begin
        m_cnt[c][i] = 0;
        m_ovf[c][i] = 0;
      end
    for (int i = 0; i < 4; i++) m_prev[i] = 0;
  endtask

  task automatic model_step(input logic [3:0] ki, input logic [3:0] dc,
                            input logic [3:0] cl, input logic e);
    for (int c = 0; c < 2; c++) begin
      int  lim;
      bit  wrap;
      lim  = (c == 0) ? 4 : 3;
      wrap = (c == 1);
      for (int i = 0; i < 4; i++) begin
        bit p, d;
        p = ki[i] && !m_prev[i] && e;
        d = dc[i] && e;
        if (cl[i]) begin
          m_cnt[c][i] = 0;
          m_ovf[c][i] = 0;
        end else if (p && d) begin
          // press and decrement cancel
        end else if (p) begin
          if (m_cnt[c][i] < lim) m_cnt[c][i]++;
          else if (wrap) begin
            m_cnt[c][i] = 0;
            m_ovf[c][i] = 1;
          end
        end else if (d && m_cnt[c][i] > 0) begin
          m_cnt[c][i]--;
        end
        if (!wrap) m_ovf[c][i] = (m_cnt[c][i] == lim);
      end
    end
    for (int i = 0; i < 4; i++) m_prev[i] = ki[i];
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    int   ts, tw;
    e  = '0;
    ts = 0;
    tw = 0;
    for (int i = 0; i < 4; i++) begin
      e.cnt_s[i*4 +: 4] = 4'(m_cnt[0][i]);
      e.cnt_w[i*4 +: 4] = 4'(m_cnt[1][i]);
      e.ovf_s[i] = m_ovf[0][i];
      e.ovf_w[i] = m_ovf[1][i];
      ts += m_cnt[0][i];
      tw += m_cnt[1][i];
    end
    e.tot_s = 7'(ts);
    e.tot_w = 7'(tw);
    e.any_s = |e.ovf_s;
    e.any_w = |e.ovf_w;
    return e;
  endfunction

  // Drive one cycle of inputs, then predict the state after the next edge.
  task automatic cycle(input logic [3:0] ki, input logic [3:0] dc,
                       input logic [3:0] cl, input logic e);
    kin = ki; kdec = dc; kclr = cl; en = e;
    @(posedge clk);
    #1;
    model_step(ki, dc, cl, e);
    sb.push_back(snapshot());
  endtask

  task automatic press(input logic [3:0] mask);
    cycle(mask, 4'h0, 4'h0, 1'b1);
    cycle(4'h0, 4'h0, 4'h0, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cnt_s"}, 32'(cnt_s), 0);
    check({tag, "_ovf_s"}, 32'(ovf_s), 0);
    check({tag, "_tot_s"}, 32'(tot_s), 0);
    check({tag, "_any_s"}, 32'(any_s), 0);
    check({tag, "_cnt_w"}, 32'(cnt_w), 0);
    check({tag, "_ovf_w"}, 32'(ovf_w), 0);
    check({tag, "_tot_w"}, 32'(tot_w), 0);
  endtask

  // Monitor: outputs are presented every cycle; compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_cnt_s", 32'(cnt_s), 32'(e.cnt_s));
        check("sb_ovf_s", 32'(ovf_s), 32'(e.ovf_s));
        check("sb_tot_s", 32'(tot_s), 32'(e.tot_s));
        check("sb_any_s", 32'(any_s), 32'(e.any_s));
        check("sb_cnt_w", 32'(cnt_w), 32'(e.cnt_w));
        check("sb_ovf_w", 32'(ovf_w), 32'(e.ovf_w));
        check("sb_tot_w", 32'(tot_w), 32'(e.tot_w));
        check("sb_any_w", 32'(any_w), 32'(e.any_w));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b0; kin = '0; kdec = '0; kclr = '0;
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Saturation on ch0: counts 1,2,3,4,4.
    repeat (5) press(4'b0001);
    check("sat_cnt0", 32'(cnt_s[3:0]), 4);
    check("sat_ovf0", 32'(ovf_s[0]), 1);
    check("sat_total", 32'(tot_s), 4);
    check("wrap_ch0_after5", 32'(cnt_w[3:0]), 1);

    // Wrap on ch1, sticky flag, then clear.
    repeat (4) press(4'b0010);
    check("wrap_cnt1", 32'(cnt_w[7:4]), 0);
    check("wrap_ovf1", 32'(ovf_w[1]), 1);
    cycle(4'h0, 4'h0, 4'b0010, 1'b1);
    check("wrap_clr_cnt1", 32'(cnt_w[7:4]), 0);
    check("wrap_clr_ovf1", 32'(ovf_w[1]), 0);
    cycle(4'h0, 4'h0, 4'b0001, 1'b0);   // clear works with enable low
    check("clr_no_en", 32'(cnt_s[3:0]), 0);

    // Decrement out of saturation, then press+decrement cancel.
    repeat (4) press(4'b0100);
    cycle(4'h0, 4'b0100, 4'h0, 1'b1);
    check("dec_cnt2", 32'(cnt_s[11:8]), 3);
    check("dec_ovf2", 32'(ovf_s[2]), 0);
    check("dec_any", 32'(any_s), 0);
    cycle(4'b0100, 4'b0100, 4'h0, 1'b1);
    cycle(4'h0, 4'h0, 4'h0, 1'b1);
    check("press_dec_cnt2", 32'(cnt_s[11:8]), 3);

    // Key held high across an enable rise does not count.
    cycle(4'b1000, 4'h0, 4'h0, 1'b0);
    cycle(4'b1000, 4'h0, 4'h0, 1'b0);
    cycle(4'b1000, 4'h0, 4'h0, 1'b1);
    cycle(4'b1000, 4'h0, 4'h0, 1'b1);
    check("en_rise_cnt3", 32'(cnt_s[15:12]), 0);
    cycle(4'h0, 4'h0, 4'h0, 1'b1);
    press(4'b1000);
    check("en_press_cnt3", 32'(cnt_s[15:12]), 1);

    // All channels at once, then clear beating a press.
    cycle(4'h0, 4'h0, 4'hF, 1'b1);
    cycle(4'hF, 4'h0, 4'h0, 1'b1);
    check("all_cnt", 32'(cnt_s), 32'h1111);
    check("all_total", 32'(tot_s), 4);
    cycle(4'h0, 4'h0, 4'h0, 1'b1);
    cycle(4'b0001, 4'h0, 4'b0001, 1'b1);
    check("clr_vs_press", 32'(cnt_s[3:0]), 0);

    // Build counts 3,2,1,4 and reset asynchronously mid-cycle.
    cycle(4'h0, 4'h0, 4'hF, 1'b1);
    press(4'hF);
    press(4'b1011);
    press(4'b1001);
    press(4'b1000);
    check("pre_rst_cnt", 32'(cnt_s), 32'h4123);
    check("pre_rst_total", 32'(tot_s), 10);
    @(negedge clk);
    #1;
    kin = 4'b0001;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b0001, 4'h0, 4'h0, 1'b1);
    cycle(4'b0001, 4'h0, 4'h0, 1'b1);
    check("held_thru_rst", 32'(cnt_s[3:0]), 1);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] ki, dc, cl;
      logic       e;
      ki = 4'($urandom);
      dc = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      cl = ($urandom_range(0, 15) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
      e  = ($urandom_range(0, 7) != 0);
      cycle(ki, dc, cl, e);
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 0);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keystroke_count_bank.md
KEYSTROKE_COUNT_BANK -- requirements
Module: keystroke_count_bank

Interface
REQ-001 Parameter N_CH, default 4: number of independent key channels, range 1..16.
REQ-002 Parameter CNT_W, default 4: per-channel count width in bits.
REQ-003 Parameter MAX_CNT, default 4: per-channel limit, 1 <= MAX_CNT <= 2^CNT_W-1.
REQ-004 Parameter WRAP_MODE, default 0: 0 = saturate at MAX_CNT, 1 = wrap to 0 after MAX_CNT.
REQ-005 key_clk  in  1  single clock; all state updates on its rising edge.
REQ-006 key_reset  in  1  reset, asynchronous, active-low.
REQ-007 key_enable  in  1  global count enable; gates press and decrement events.
REQ-008 key_in  in  N_CH  key levels, already synchronous to key_clk and debounced.
REQ-009 key_dec  in  N_CH  per-channel decrement request, single-cycle strobe.
REQ-010 key_clear  in  N_CH  per-channel synchronous clear, single-cycle strobe.
REQ-011 key_count  out  N_CH*CNT_W  packed counts, channel i at bits [i*CNT_W +: CNT_W].
REQ-012 key_overflow  out  N_CH  per-channel limit/overflow flag.
REQ-013 key_total  out  CNT_W+clog2(N_CH)+1  sum of all channel counts.
REQ-014 key_any_full  out  1  OR of all key_overflow bits.

Function
REQ-015 Press event i SHALL be: key_in[i]=1 this cycle, key_in[i]=0 previous cycle, key_enable=1.
REQ-016 Previous-level register SHALL track key_in every cycle regardless of key_enable; a key held across an enable rise SHALL NOT count.
REQ-017 Decrement event i SHALL be key_dec[i]=1 with key_enable=1.
REQ-018 Counts SHALL update one cycle after the qualifying input cycle (registered, latency 1).
REQ-019 Priority per channel: key_clear > (press and decrement together) > press > decrement.
REQ-020 key_clear[i] SHALL set count to 0 and key_overflow[i] to 0, regardless of key_enable.
REQ-021 Simultaneous press and decrement SHALL leave count and key_overflow unchanged.
REQ-022 Decrement at count 0 SHALL be ignored.
REQ-023 Saturate mode: press below MAX_CNT increments; press at MAX_CNT ignored.
REQ-024 Saturate mode: key_overflow[i] SHALL equal (count==MAX_CNT), asserting in the same cycle count reaches MAX_CNT and deasserting when a decrement takes it below.
REQ-025 Wrap mode: press at MAX_CNT SHALL set count to 0 and set key_overflow[i] sticky until clear or reset.
REQ-026 Wrap mode: decrement SHALL NOT affect key_overflow[i].
REQ-027 key_total SHALL be registered and consistent with key_count in the same cycle, never lagging.
REQ-028 key_any_full SHALL be combinational OR of key_overflow.
REQ-029 No arithmetic SHALL exceed CNT_W; internal compares use MAX_CNT at CNT_W width.

Reset
REQ-030 On key_reset low, immediately: all counts 0, key_overflow 0, key_total 0, previous-level registers 0.
REQ-031 Reset mid-press: a key held high through reset release SHALL count once on the first cycle after release.
REQ-032 Reset deassertion SHALL take effect at the next key_clk rising edge.

Structure
REQ-033 Package keystroke_pkg SHALL hold mode constants (MODE_SATURATE, MODE_WRAP) and the clog2 function.
REQ-034 Sub-module keystroke_channel (edge detect, one counter, overflow flag) SHALL be instantiated N_CH times by generate; the top holds only summation and key_any_full.

Verification
REQ-035 Defaults, ch0 pressed 5 separate times -> counts 1,2,3,4,4; key_overflow[0]=1 from 4th press; key_total=4.
REQ-036 WRAP_MODE=1, MAX_CNT=3, ch1 pressed 4 times -> count 1,2,3,0; key_overflow[1] sticky 1; key_clear[1] -> count 0, flag 0.
REQ-037 ch2 at 4 (saturated), key_dec[2] -> count 3, key_overflow[2]=0, key_any_full=0; press + key_dec same cycle at 3 -> remains 3.
REQ-038 key_enable=0 while ch3 rises and stays high, enable then 1 -> count stays 0; release and press -> 1.
REQ-039 All 4 channels pressed same cycle from 0 -> next cycle each 1, key_total=4; key_clear[0] with press[0] same cycle -> count0=0.
REQ-040 key_reset pulsed low mid-cycle with counts 3,2,1,4 -> all outputs 0 before next clock edge.
